// File: rtl/sumador_nbits_secuencial.sv
// Sequential N-bit adder/subtractor that processes PASO bits per clock,
// LSB slice first, and publishes the full result with a one-cycle listo pulse.
module sumador_nbits_secuencial #(
  parameter int ANCHO = 16,
  parameter int PASO  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic             modo,
  input  logic [ANCHO-1:0] A,
  input  logic [ANCHO-1:0] B,
  input  logic             Acarreo_entrada,
  output logic [ANCHO-1:0] Suma,
  output logic             Acarreo_salida,
  output logic             Desbordamiento,
  output logic             ocupado,
  output logic             listo
);

  localparam int NPASOS = ANCHO / PASO;
  localparam int CW = (NPASOS > 1) ? $clog2(NPASOS) : 1;

  localparam logic [1:0] REPOSO  = 2'd0;
  localparam logic [1:0] SUMANDO = 2'd1;
  localparam logic [1:0] FIN     = 2'd2;

  logic [1:0]       r_estado;
  logic [CW-1:0]    r_cnt;
  logic [ANCHO-1:0] r_a;
  logic [ANCHO-1:0] r_b;
  logic [ANCHO-1:0] r_acc;
  logic             r_carry;

  logic [PASO-1:0]  w_a;
  logic [PASO-1:0]  w_b;
  logic [PASO:0]    w_sum;
  logic             w_c_msb;
  logic             w_ultimo;
  logic             w_acepta;
  logic [ANCHO-1:0] w_res;

  assign w_a = r_a[int'(r_cnt)*PASO +: PASO];
  assign w_b = r_b[int'(r_cnt)*PASO +: PASO];
  assign w_sum = {1'b0, w_a} + {1'b0, w_b}
               + {{PASO{1'b0}}, r_carry};
  // Carry into the top bit recovered from sum = a ^ b ^ cin.
  assign w_c_msb = w_sum[PASO-1] ^ w_a[PASO-1] ^ w_b[PASO-1];
  assign w_ultimo = (int'(r_cnt) == NPASOS - 1);
  assign w_acepta = inicio && (r_estado != SUMANDO);

  always_comb begin
    w_res = r_acc;
    w_res[int'(r_cnt)*PASO +: PASO] = w_sum[PASO-1:0];
  end

  assign ocupado = (r_estado == SUMANDO);
  assign listo   = (r_estado == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado       <= REPOSO;
      r_cnt          <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_acc          <= '0;
      r_carry        <= 1'b0;
      Suma           <= '0;
      Acarreo_salida <= 1'b0;
      Desbordamiento <= 1'b0;
    end else if (w_acepta) begin
      // Subtraction folds into addition: A + ~B + ~borrow.
      r_estado <= SUMANDO;
      r_cnt    <= '0;
      r_a      <= A;
      r_b      <= modo ? ~B : B;
      r_carry  <= modo ? ~Acarreo_entrada : Acarreo_entrada;
    end else if (r_estado == SUMANDO) begin
      r_acc   <= w_res;
      r_carry <= w_sum[PASO];
      if (w_ultimo) begin
        r_estado       <= FIN;
        Suma           <= w_res;
        Acarreo_salida <= w_sum[PASO];
        Desbordamiento <= w_c_msb ^ w_sum[PASO];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_estado <= REPOSO;
    end
  end

endmodule

// File: tb/tb_sumador_nbits_secuencial.sv
// Directed bench for sumador_nbits_secuencial: 16/4 and 8/1 configurations,
// checking results, latency, throughput, inicio masking and reset abort.
module tb_sumador_nbits_secuencial;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio, modo, cin;
  logic [15:0] a, b;
  logic [15:0] suma;
  logic        cout, ovf, ocupado, listo;

  logic        inicio8, modo8, cin8;
  logic [7:0]  a8, b8, suma8;
  logic        cout8, ovf8, ocupado8, listo8;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  sumador_nbits_secuencial #(.ANCHO(16), .PASO(4)) u_dut16 (
    .clk(clk), .rst(rst), .inicio(inicio), .modo(modo),
    .A(a), .B(b), .Acarreo_entrada(cin),
    .Suma(suma), .Acarreo_salida(cout),
    .Desbordamiento(ovf), .ocupado(ocupado), .listo(listo)
  );

  sumador_nbits_secuencial #(.ANCHO(8), .PASO(1)) u_dut8 (
    .clk(clk), .rst(rst), .inicio(inicio8), .modo(modo8),
    .A(a8), .B(b8), .Acarreo_entrada(cin8),
    .Suma(suma8), .Acarreo_salida(cout8),
    .Desbordamiento(ovf8), .ocupado(ocupado8), .listo(listo8)
  );

  task automatic chequear(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation on the 16/4 unit and check result and timing.
  task automatic op16(input string tag, input logic m,
                      input logic [15:0] va, input logic [15:0] vb,
                      input logic vc, input logic [15:0] es,
                      input logic ec, input logic eo);
    int lat;
    int ocup;
    modo = m; a = va; b = vb; cin = vc; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    lat = 0; ocup = 0;
    while (!listo && lat < 20) begin
      if (ocupado) ocup++;
      @(negedge clk);
      lat++;
    end
    chequear({tag, " lat"}, lat, 4);
    chequear({tag, " ocup"}, ocup, 4);
    chequear({tag, " suma"}, suma, es);
    chequear({tag, " cout"}, cout, ec);
    chequear({tag, " ovf"}, ovf, eo);
    @(negedge clk);
    chequear({tag, " pulse"}, listo, 0);
    chequear({tag, " hold"}, suma, es);
  endtask

  initial begin
    int lat;
    int per;
    rst = 1'b1; inicio = 1'b1; modo = 1'b0; cin = 1'b0;
    a = 16'h1111; b = 16'h2222;
    inicio8 = 1'b0; modo8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    @(negedge clk);
    @(negedge clk);
    chequear("rst ocupado", ocupado, 0);
    chequear("rst listo", listo, 0);
    chequear("rst suma", suma, 0);
    chequear("rst cout", cout, 0);
    chequear("rst ovf", ovf, 0);
    inicio = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    op16("add", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    op16("wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("ovfp", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("sub", 1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    op16("subov", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    op16("cin", 1'b0, 16'h00F0, 16'h000F, 1'b1, 16'h0100, 1'b0, 1'b0);
    op16("bin", 1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0);

    // inicio with new operands during SUMANDO must be ignored
    modo = 1'b0; a = 16'h1234; b = 16'h4321; cin = 1'b0; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h0001; cin = 1'b1; modo = 1'b1; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    lat = 0;
    while (!listo && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chequear("ign lat", lat, 2);
    chequear("ign suma", suma, 16'h5555);
    @(negedge clk);
    chequear("ign no restart", ocupado, 0);

    // inicio held high: back-to-back, one listo every 5 cycles
    modo = 1'b0; a = 16'h0001; b = 16'h0002; cin = 1'b0; inicio = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!listo && lat < 20);
    chequear("b2b first", lat, 5);
    per = 0;
    do begin
      @(negedge clk);
      per++;
    end while (!listo && per < 20);
    chequear("b2b period", per, 5);
    chequear("b2b suma", suma, 16'h0003);
    inicio = 1'b0;
    repeat (6) @(negedge clk);

    // reset on edge 2 of an operation aborts it
    modo = 1'b0; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chequear("abort suma", suma, 0);
    chequear("abort ocupado", ocupado, 0);
    chequear("abort listo", listo, 0);
    lat = 0;
    repeat (6) begin
      @(negedge clk);
      if (listo) lat++;
    end
    chequear("abort nolisto", lat, 0);
    op16("post", 1'b0, 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    // 8-bit, 1 bit per cycle
    modo8 = 1'b0; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; inicio8 = 1'b1;
    @(negedge clk);
    inicio8 = 1'b0;
    lat = 0;
    while (!listo8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chequear("p1 lat", lat, 8);
    chequear("p1 suma", suma8, 8'h01);
    chequear("p1 cout", cout8, 1);
    chequear("p1 ovf", ovf8, 1);
    modo8 = 1'b1; a8 = 8'h03; b8 = 8'h05; cin8 = 1'b0; inicio8 = 1'b1;
    @(negedge clk);
    inicio8 = 1'b0;
    lat = 0;
    while (!listo8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chequear("p1s lat", lat, 8);
    chequear("p1s suma", suma8, 8'hFE);
    chequear("p1s cout", cout8, 0);
    chequear("p1s ovf", ovf8, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sumador_nbits_secuencial.md
SUMADOR_NBITS_SECUENCIAL -- requirements
Module: sumador_nbits_secuencial

Interface
REQ-001 The block SHALL expose parameter ANCHO, default 16: operand and result width in bits.
REQ-002 The block SHALL expose parameter PASO, default 4: bits added per clock cycle; ANCHO SHALL be an integer multiple of PASO, with 1 <= PASO <= ANCHO.
REQ-003 The block SHALL have exactly one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 inicio  input  1  start request; one cycle high suffices.
REQ-007 modo  input  1  0 = A+B+Acarreo_entrada; 1 = A-B-Acarreo_entrada (borrow-in).
REQ-008 A  input  ANCHO  operand A.
REQ-009 B  input  ANCHO  operand B.
REQ-010 Acarreo_entrada  input  1  carry-in (modo=0) or borrow-in (modo=1).
REQ-011 Suma  output  ANCHO  registered result.
REQ-012 Acarreo_salida  output  1  carry out of the MSB; for modo=1 it reads 1 = no borrow.
REQ-013 Desbordamiento  output  1  two's-complement overflow of the result.
REQ-014 ocupado  output  1  high while an operation is in progress.
REQ-015 listo  output  1  one-cycle pulse marking new valid results.

Function
REQ-016 The FSM SHALL have states REPOSO, SUMANDO and FIN.
REQ-017 REPOSO or FIN with inicio=1 SHALL latch A, B, modo and Acarreo_entrada, clear the slice counter, and move to SUMANDO; otherwise REPOSO SHALL stay in REPOSO.
REQ-018 In SUMANDO, each clock edge SHALL add one PASO-bit slice, LSB slice first, into an internal result register, propagating carry between slices.
REQ-019 The added operand SHALL be ~B when modo=1 and B when modo=0; the effective carry-in SHALL be ~Acarreo_entrada when modo=1 and Acarreo_entrada when modo=0.
REQ-020 After the NPASOS = ANCHO/PASO-th slice edge, the block SHALL load Suma, Acarreo_salida and Desbordamiento in the same edge and enter FIN.
REQ-021 Desbordamiento SHALL equal (carry into the MSB) XOR (carry out of the MSB).
REQ-022 listo SHALL be high only in FIN; FIN SHALL last one cycle, then return to REPOSO unless inicio restarts (REQ-017).
REQ-023 Latency: the edge that accepts inicio is edge 0; listo SHALL be high in the cycle after edge NPASOS.
REQ-024 Back-to-back operation SHALL be possible, giving one result per NPASOS+1 cycles.
REQ-025 ocupado SHALL be high exactly in SUMANDO.
REQ-026 inicio SHALL be ignored while ocupado=1, and latched operands SHALL be unaffected by input changes during SUMANDO.
REQ-027 Suma, Acarreo_salida and Desbordamiento SHALL hold their last values until the next FIN entry; partial sums SHALL never appear on Suma.
REQ-028 For PASO = ANCHO, NPASOS = 1 and the result SHALL appear with listo one cycle after acceptance.

Reset
REQ-029 rst=1 at a clock edge SHALL force state REPOSO and clear the slice counter, internal result and carry, Suma, Acarreo_salida, Desbordamiento, ocupado and listo to 0.
REQ-030 rst SHALL take priority over inicio.
REQ-031 Reset mid-operation SHALL abort the operation with no listo pulse for it.

Verification (ANCHO=16, PASO=4 unless noted)
REQ-032 modo=0, A=0x1234, B=0x4321, cin=0 -> Suma=0x5555, Acarreo_salida=0, Desbordamiento=0; listo high in the cycle after edge 4; ocupado high for exactly 4 cycles.
REQ-033 modo=0, A=0xFFFF, B=0x0001, cin=0 -> Suma=0x0000, Acarreo_salida=1, Desbordamiento=0; then A=0x7FFF, B=0x0001 -> Suma=0x8000, Acarreo_salida=0, Desbordamiento=1.
REQ-034 modo=1, A=0x0005, B=0x0007, cin=0 -> Suma=0xFFFE, Acarreo_salida=0 (borrow), Desbordamiento=0; A=0x8000, B=0x0001 -> Suma=0x7FFF, Desbordamiento=1.
REQ-035 inicio pulsed with new operands during SUMANDO -> ignored, and the first result is unchanged; inicio held high through FIN -> second operation starts, so listo pulses every 5 cycles.
REQ-036 rst asserted on edge 2 of an operation -> all outputs 0, no listo; next inicio completes normally.
REQ-037 ANCHO=8, PASO=1: A=0x80, B=0x80, cin=1 -> Suma=0x01, Acarreo_salida=1, Desbordamiento=1; listo in the cycle after edge 8.
